// File: rtl/battle_pkg.sv
// battle_pkg: shared response codes, responder states, board defaults and cell indexing
package battle_pkg;
  localparam int GRID_N_DEF = 10;
  localparam int SHIP_CELLS_DEF = 20;
  localparam int IDX_W_DEF = 7;
  typedef enum logic [1:0] {RESP_NONE, RESP_MISS, RESP_HIT, RESP_HIT_LAST} resp_t;
  typedef enum logic [2:0] {S_IDLE, S_READY, S_LOOKUP, S_RESPOND, S_DONE} state_t;
  // row*grid+col; 8 bits covers any 4-bit row/col, callers truncate to their index width
  function automatic logic [7:0] cell_idx(input logic [3:0] row, input logic [3:0] col, input int grid = GRID_N_DEF);
    return 8'(row) * 8'(grid) + 8'(col);
  endfunction
endpackage

// File: rtl/shot_responder_mask.sv
// shot_mask: per-cell already-hit flags with synchronous clear, set and combinational query
module shot_mask #(
  parameter int N = 100,
  parameter int IDX_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             set,
  input  logic [IDX_W-1:0] idx,
  output logic             query
);
  logic [N-1:0] bits;
  always_ff @(posedge clk or negedge rst)
    if (!rst) bits <= '0;
    else if (clr) bits <= '0;
    else if (set) bits[idx] <= 1'b1;
  assign query = bits[idx];
endmodule

// File: rtl/shot_responder.sv
// shot_responder: looks up opponent shots in the board RAM and answers MISS/HIT/HIT_LAST.
// REPEAT_SHOT_CHECK_EN adds a shot mask so repeat hits on the same cell answer MISS.
module shot_responder
  import battle_pkg::*;
#(
  parameter int GRID_N = GRID_N_DEF,
  parameter int SHIP_CELLS = SHIP_CELLS_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             shot_valid,
  input  logic [7:0]       shot_addr,
  output logic             shot_ready,
  output logic             board_rd_en,
  output logic [IDX_W-1:0] board_rd_addr,
  input  logic             board_rd_data,
  output logic             resp_valid,
  output logic [1:0]       resp_code,
  input  logic             resp_ready,
  output logic [4:0]       cells_left,
  output logic             fleet_sunk
);
  state_t state, state_nx;
  logic accept, legal, legal_q, mask_hit, hit, start, lookup;
  assign legal = int'(shot_addr[7:4]) < GRID_N && int'(shot_addr[3:0]) < GRID_N;
  assign board_rd_addr = IDX_W'(cell_idx(shot_addr[7:4], shot_addr[3:0], GRID_N));
  assign accept = shot_valid & shot_ready;
  assign start = state == S_IDLE && arm;
  assign lookup = state == S_LOOKUP && arm;
  assign hit = legal_q & board_rd_data & ~mask_hit & (cells_left != 5'd0);
  assign fleet_sunk = state == S_DONE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= S_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    shot_ready = 1'b0;
    board_rd_en = 1'b0;
    case (state)
      S_IDLE: state_nx = arm ? S_READY : S_IDLE;
      S_READY: begin
        shot_ready = 1'b1;
        board_rd_en = shot_valid & legal;
        state_nx = !arm ? S_IDLE : shot_valid ? S_LOOKUP : S_READY;
      end
      S_LOOKUP: state_nx = arm ? S_RESPOND : S_IDLE;
      S_RESPOND: state_nx = !arm ? S_IDLE : !resp_ready ? S_RESPOND : cells_left == 5'd0 ? S_DONE : S_READY;
      S_DONE: state_nx = arm ? S_DONE : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      legal_q <= 1'b0;
      cells_left <= 5'(SHIP_CELLS);
      resp_valid <= 1'b0;
      resp_code <= RESP_NONE;
    end else begin
      if (start) cells_left <= 5'(SHIP_CELLS);
      if (accept) legal_q <= legal;
      if (lookup) begin
        resp_valid <= 1'b1;
        resp_code <= hit ? (cells_left == 5'd1 ? RESP_HIT_LAST : RESP_HIT) : RESP_MISS;
        if (hit) cells_left <= cells_left - 5'd1;
      end
      if (state == S_RESPOND && (resp_ready || !arm)) begin
        resp_valid <= 1'b0;
        resp_code <= RESP_NONE;
      end
    end
`ifdef REPEAT_SHOT_CHECK_EN
  logic [IDX_W-1:0] idx_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) idx_q <= '0;
    else if (accept) idx_q <= board_rd_addr;
  shot_mask #(.N(GRID_N * GRID_N), .IDX_W(IDX_W)) u_mask (
    .clk(clk),
    .rst(rst),
    .clr(start),
    .set(lookup & hit),
    .idx(idx_q),
    .query(mask_hit)
  );
`else
  assign mask_hit = 1'b0;
`endif
endmodule

// File: tb/tb_shot_responder.sv
// tb_shot_responder: directed checks of shot lookup, handshake, abort and fleet-sunk behaviour
module tb_shot_responder;
  logic clk = 0, rst = 0, arm = 0, shot_valid = 0, resp_ready = 1, board_rd_data = 0;
  logic [7:0] shot_addr = 0;
  logic shot_ready, board_rd_en, resp_valid, fleet_sunk;
  logic [6:0] board_rd_addr;
  logic [1:0] resp_code;
  logic [4:0] cells_left;
  logic board [128];
  int pass_n = 0, total = 0;
  logic [4:0] left_exp;
  logic rdy, en, v1, v2;
  logic [6:0] ra;
  logic [1:0] code;

  shot_responder dut (
    .clk(clk), .rst(rst), .arm(arm), .shot_valid(shot_valid), .shot_addr(shot_addr),
    .shot_ready(shot_ready), .board_rd_en(board_rd_en), .board_rd_addr(board_rd_addr),
    .board_rd_data(board_rd_data), .resp_valid(resp_valid), .resp_code(resp_code),
    .resp_ready(resp_ready), .cells_left(cells_left), .fleet_sunk(fleet_sunk)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (board_rd_en) board_rd_data <= board[board_rd_addr];

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shoot(input logic [7:0] a, output logic ok, output logic e, output logic [6:0] addr,
                       output logic lv, output logic rv, output logic [1:0] c);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) if (shot_ready) ok = 1; else tick();
    shot_valid = 1;
    shot_addr = a;
    #1;
    e = board_rd_en;
    addr = board_rd_addr;
    tick();
    shot_valid = 0;
    lv = resp_valid;
    tick();
    rv = resp_valid;
    c = resp_code;
    if (resp_ready) tick();
  endtask

  task automatic test_reset();
    rst = 0; arm = 1;
    tick(); tick();
    total++; if (shot_ready !== 1'b0) $display("FAIL reset_shot_ready got %b want 0", shot_ready); else pass_n++;
    total++; if ({resp_valid, resp_code} !== 3'b000) $display("FAIL reset_resp got %b want 000", {resp_valid, resp_code}); else pass_n++;
    total++; if (board_rd_en !== 1'b0) $display("FAIL reset_rd_en got %b want 0", board_rd_en); else pass_n++;
    total++; if (cells_left !== 5'd20) $display("FAIL reset_cells_left got %0d want 20", cells_left); else pass_n++;
    total++; if (fleet_sunk !== 1'b0) $display("FAIL reset_fleet_sunk got %b want 0", fleet_sunk); else pass_n++;
    rst = 1;
    tick();
    total++; if (shot_ready !== 1'b1) $display("FAIL armed_shot_ready got %b want 1", shot_ready); else pass_n++;
  endtask

  task automatic test_miss();
    shoot(8'h34, rdy, en, ra, v1, v2, code);
    total++; if (rdy !== 1'b1) $display("FAIL miss_ready got %b want 1", rdy); else pass_n++;
    total++; if (en !== 1'b1) $display("FAIL miss_rd_en got %b want 1", en); else pass_n++;
    total++; if (ra !== 7'd34) $display("FAIL miss_rd_addr got %0d want 34", ra); else pass_n++;
    total++; if (v1 !== 1'b0) $display("FAIL miss_early_valid got %b want 0", v1); else pass_n++;
    total++; if ({v2, code} !== 3'b101) $display("FAIL miss_resp got %b want 101", {v2, code}); else pass_n++;
    total++; if (cells_left !== 5'd20) $display("FAIL miss_cells_left got %0d want 20", cells_left); else pass_n++;
  endtask

  task automatic test_hit();
    board[34] = 1;
    shoot(8'h34, rdy, en, ra, v1, v2, code);
    total++; if ({v2, code} !== 3'b110) $display("FAIL hit_resp got %b want 110", {v2, code}); else pass_n++;
    total++; if (cells_left !== 5'd19) $display("FAIL hit_cells_left got %0d want 19", cells_left); else pass_n++;
    shoot(8'h34, rdy, en, ra, v1, v2, code);
`ifdef REPEAT_SHOT_CHECK_EN
    total++; if ({v2, code} !== 3'b101) $display("FAIL repeat_resp got %b want 101", {v2, code}); else pass_n++;
    left_exp = 5'd19;
`else
    total++; if ({v2, code} !== 3'b110) $display("FAIL repeat_resp got %b want 110", {v2, code}); else pass_n++;
    left_exp = 5'd18;
`endif
    total++; if (cells_left !== left_exp) $display("FAIL repeat_cells_left got %0d want %0d", cells_left, left_exp); else pass_n++;
  endtask

  task automatic test_illegal();
    board[102] = 1;
    shoot(8'hA2, rdy, en, ra, v1, v2, code);
    total++; if (en !== 1'b0) $display("FAIL illegal_row_rd_en got %b want 0", en); else pass_n++;
    total++; if ({v2, code} !== 3'b101) $display("FAIL illegal_row_resp got %b want 101", {v2, code}); else pass_n++;
    shoot(8'h3C, rdy, en, ra, v1, v2, code);
    total++; if (en !== 1'b0) $display("FAIL illegal_col_rd_en got %b want 0", en); else pass_n++;
    total++; if ({v2, code} !== 3'b101) $display("FAIL illegal_col_resp got %b want 101", {v2, code}); else pass_n++;
    total++; if (cells_left !== left_exp) $display("FAIL illegal_cells_left got %0d want %0d", cells_left, left_exp); else pass_n++;
  endtask

  task automatic test_back_to_back();
    board[55] = 1;
    resp_ready = 0;
    shot_valid = 1;
    shot_addr = 8'h55;
    tick();
    tick();
    left_exp = left_exp - 5'd1;
    for (int i = 0; i < 5; i++) begin
      total++; if ({resp_valid, resp_code} !== 3'b110) $display("FAIL hold_resp cycle %0d got %b want 110", i, {resp_valid, resp_code}); else pass_n++;
      total++; if (shot_ready !== 1'b0) $display("FAIL hold_shot_ready cycle %0d got %b want 0", i, shot_ready); else pass_n++;
      tick();
    end
    total++; if (cells_left !== left_exp) $display("FAIL hold_cells_left got %0d want %0d", cells_left, left_exp); else pass_n++;
    resp_ready = 1;
    tick();
    total++; if ({shot_ready, resp_valid} !== 2'b10) $display("FAIL handshake_done got %b want 10", {shot_ready, resp_valid}); else pass_n++;
    tick();
    shot_valid = 0;
    tick();
`ifdef REPEAT_SHOT_CHECK_EN
    total++; if ({resp_valid, resp_code} !== 3'b101) $display("FAIL second_shot_resp got %b want 101", {resp_valid, resp_code}); else pass_n++;
`else
    left_exp = left_exp - 5'd1;
    total++; if ({resp_valid, resp_code} !== 3'b110) $display("FAIL second_shot_resp got %b want 110", {resp_valid, resp_code}); else pass_n++;
`endif
    total++; if (cells_left !== left_exp) $display("FAIL second_shot_cells_left got %0d want %0d", cells_left, left_exp); else pass_n++;
    tick();
  endtask

  task automatic test_abort();
    board[66] = 1;
    shot_valid = 1;
    shot_addr = 8'h66;
    tick();
    shot_valid = 0;
    arm = 0;
    tick();
    total++; if ({resp_valid, shot_ready} !== 2'b00) $display("FAIL abort_lookup_outputs got %b want 00", {resp_valid, shot_ready}); else pass_n++;
    total++; if (cells_left !== left_exp) $display("FAIL abort_lookup_cells_left got %0d want %0d", cells_left, left_exp); else pass_n++;
    arm = 1;
    tick();
    total++; if (cells_left !== 5'd20) $display("FAIL rearm_cells_left got %0d want 20", cells_left); else pass_n++;
    resp_ready = 0;
    shot_valid = 1;
    tick();
    shot_valid = 0;
    tick();
    total++; if ({resp_valid, resp_code, cells_left} !== {3'b110, 5'd19}) $display("FAIL abort_respond_pre got %b/%0d want 110/19", {resp_valid, resp_code}, cells_left); else pass_n++;
    arm = 0;
    tick();
    total++; if ({resp_valid, resp_code} !== 3'b000) $display("FAIL abort_respond_resp got %b want 000", {resp_valid, resp_code}); else pass_n++;
    total++; if (cells_left !== 5'd19) $display("FAIL abort_respond_cells_left got %0d want 19", cells_left); else pass_n++;
    resp_ready = 1;
    arm = 1;
    tick();
  endtask

  task automatic test_sunk();
    for (int i = 0; i < 128; i++) board[i] = 0;
    for (int r = 0; r < 2; r++) for (int c = 0; c < 10; c++) board[r * 10 + c] = 1;
    for (int k = 0; k < 20; k++) begin
      shoot({4'(k / 10), 4'(k % 10)}, rdy, en, ra, v1, v2, code);
      total++; if ({v2, code} !== (k == 19 ? 3'b111 : 3'b110)) $display("FAIL sunk_shot %0d got %b want %b", k, {v2, code}, (k == 19 ? 3'b111 : 3'b110)); else pass_n++;
    end
    total++; if ({fleet_sunk, shot_ready} !== 2'b10) $display("FAIL done_outputs got %b want 10", {fleet_sunk, shot_ready}); else pass_n++;
    total++; if (cells_left !== 5'd0) $display("FAIL done_cells_left got %0d want 0", cells_left); else pass_n++;
    arm = 0;
    tick();
    total++; if ({fleet_sunk, shot_ready} !== 2'b00) $display("FAIL idle_after_done got %b want 00", {fleet_sunk, shot_ready}); else pass_n++;
  endtask

  task automatic test_reset_mid_lookup();
    board[66] = 1;
    arm = 1;
    tick();
    shot_valid = 1;
    shot_addr = 8'h66;
    tick();
    shot_valid = 0;
    rst = 0;
    #1;
    total++; if ({resp_valid, shot_ready, board_rd_en} !== 3'b000) $display("FAIL rst_mid_outputs got %b want 000", {resp_valid, shot_ready, board_rd_en}); else pass_n++;
    total++; if (cells_left !== 5'd20) $display("FAIL rst_mid_cells_left got %0d want 20", cells_left); else pass_n++;
    tick();
    rst = 1;
    tick();
    total++; if ({shot_ready, resp_valid} !== 2'b10) $display("FAIL rst_mid_rearm got %b want 10", {shot_ready, resp_valid}); else pass_n++;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) board[i] = 0;
    left_exp = 5'd20;
    test_reset();
    test_miss();
    test_hit();
    test_illegal();
    test_back_to_back();
    test_abort();
    test_sunk();
    test_reset_mid_lookup();
    $display("%0d/%0d checks passed", pass_n, total);
    $finish;
  end
endmodule
